// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control sequencer: steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives datapath enables one phase at a time.
module multicycle_controller #(
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic                     fetch_ack,
    input  logic                     mem_ack,
    input  logic                     branch_taken,
    output logic                     fetch_req,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     pc_source,
    output logic                     mem_req,
    output logic                     memory_read,
    output logic                     memory_write,
    output logic                     memory_to_register,
    output logic                     alu_source,
    output logic [3:0]               alu_option,
    output logic [1:0]               AuipcLui,
    output logic                     branch,
    output logic                     register_write,
    output logic                     illegal_instr,
    output logic [COUNTER_WIDTH-1:0] instret
);

    localparam logic [2:0] StFetch     = 3'd0;
    localparam logic [2:0] StDecode    = 3'd1;
    localparam logic [2:0] StExecute   = 3'd2;
    localparam logic [2:0] StMemory    = 3'd3;
    localparam logic [2:0] StWriteback = 3'd4;

    localparam logic [2:0] ClsLoad    = 3'd0;
    localparam logic [2:0] ClsItype   = 3'd1;
    localparam logic [2:0] ClsAuipc   = 3'd2;
    localparam logic [2:0] ClsStore   = 3'd3;
    localparam logic [2:0] ClsRtype   = 3'd4;
    localparam logic [2:0] ClsLui     = 3'd5;
    localparam logic [2:0] ClsBranch  = 3'd6;
    localparam logic [2:0] ClsIllegal = 3'd7;

    logic [2:0]               state_q, state_d;
    logic [6:0]               opcode_q;
    logic [2:0]               class_q;
    logic [2:0]               class_in;
    logic [3:0]               key_in;
    logic [COUNTER_WIDTH-1:0] instret_q;
    logic                     retire;

    // Bits outside the class key carry no control meaning here.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^{opcode[3], opcode[1:0], opcode_q[3], opcode_q[1:0]};

    assign key_in = {opcode[6:4], opcode[2]};

    always_comb begin
        case (key_in)
            4'b0000: class_in = ClsLoad;
            4'b0010: class_in = ClsItype;
            4'b0011: class_in = ClsAuipc;
            4'b0100: class_in = ClsStore;
            4'b0110: class_in = ClsRtype;
            4'b0111: class_in = ClsLui;
            4'b1100: class_in = ClsBranch;
            default: class_in = ClsIllegal;
        endcase
    end

    always_comb begin
        fetch_req          = 1'b0;
        ir_write           = 1'b0;
        pc_write           = 1'b0;
        pc_source          = 1'b0;
        mem_req            = 1'b0;
        memory_read        = 1'b0;
        memory_write       = 1'b0;
        memory_to_register = 1'b0;
        alu_source         = 1'b0;
        alu_option         = 4'b0000;
        AuipcLui           = 2'b00;
        branch             = 1'b0;
        register_write     = 1'b0;
        illegal_instr      = 1'b0;
        retire             = 1'b0;
        state_d            = state_q;

        // Everything stays quiet during reset so no write escapes an abandoned instruction.
        if (!reset) begin
            AuipcLui   = 2'b10;
            alu_option = {opcode_q[6:4], opcode_q[2]};
            case (state_q)
                StFetch: begin
                    fetch_req = 1'b1;
                    if (fetch_ack) begin
                        ir_write = 1'b1;
                        state_d  = StDecode;
                    end
                end
                StDecode: begin
                    if (class_in == ClsIllegal) begin
                        illegal_instr = 1'b1;
                        pc_write      = 1'b1;
                        state_d       = StFetch;
                    end else begin
                        state_d = StExecute;
                    end
                end
                StExecute: begin
                    state_d = StWriteback;
                    case (class_q)
                        ClsLoad, ClsStore: begin
                            alu_source = 1'b1;
                            state_d    = StMemory;
                        end
                        ClsItype: alu_source = 1'b1;
                        ClsAuipc: begin
                            alu_source = 1'b1;
                            AuipcLui   = 2'b00;
                        end
                        ClsLui: begin
                            alu_source = 1'b1;
                            AuipcLui   = 2'b01;
                        end
                        ClsBranch: begin
                            branch    = 1'b1;
                            pc_write  = 1'b1;
                            pc_source = branch_taken;
                            retire    = 1'b1;
                            state_d   = StFetch;
                        end
                        default: ;
                    endcase
                end
                StMemory: begin
                    mem_req      = 1'b1;
                    memory_read  = (class_q == ClsLoad);
                    memory_write = (class_q == ClsStore);
                    if (mem_ack) begin
                        if (class_q == ClsLoad) begin
                            state_d = StWriteback;
                        end else begin
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            state_d  = StFetch;
                        end
                    end
                end
                StWriteback: begin
                    register_write     = 1'b1;
                    memory_to_register = (class_q == ClsLoad);
                    pc_write           = 1'b1;
                    retire             = 1'b1;
                    state_d            = StFetch;
                end
                default: state_d = StFetch;
            endcase
        end
    end

    assign instret = reset ? '0 : instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            opcode_q  <= 7'd0;
            class_q   <= ClsLoad;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                opcode_q <= opcode;
                class_q  <= class_in;
            end
            if (retire) begin
                instret_q <= instret_q + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: builds each instruction's expected per-cycle trace from the
// phase rules, plays it into the controller and compares every cycle.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        fetch_ack = 1'b0;
    logic        mem_ack = 1'b0;
    logic        branch_taken = 1'b0;
    logic        fetch_req, ir_write, pc_write, pc_source, mem_req, memory_read, memory_write;
    logic        memory_to_register, alu_source, branch, register_write, illegal_instr;
    logic [3:0]  alu_option;
    logic [1:0]  AuipcLui;
    logic [31:0] instret;

    multicycle_controller #(.COUNTER_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .fetch_ack(fetch_ack), .mem_ack(mem_ack),
        .branch_taken(branch_taken), .fetch_req(fetch_req), .ir_write(ir_write),
        .pc_write(pc_write), .pc_source(pc_source), .mem_req(mem_req),
        .memory_read(memory_read), .memory_write(memory_write),
        .memory_to_register(memory_to_register), .alu_source(alu_source),
        .alu_option(alu_option), .AuipcLui(AuipcLui), .branch(branch),
        .register_write(register_write), .illegal_instr(illegal_instr), .instret(instret)
    );

    always #5 clk = ~clk;

    // Control-bit positions in the packed expectation vector.
    localparam logic [11:0] FREQ = 12'b1000_0000_0000;
    localparam logic [11:0] IRW  = 12'b0100_0000_0000;
    localparam logic [11:0] PCW  = 12'b0010_0000_0000;
    localparam logic [11:0] PCS  = 12'b0001_0000_0000;
    localparam logic [11:0] MREQ = 12'b0000_1000_0000;
    localparam logic [11:0] MRD  = 12'b0000_0100_0000;
    localparam logic [11:0] MWR  = 12'b0000_0010_0000;
    localparam logic [11:0] M2R  = 12'b0000_0001_0000;
    localparam logic [11:0] ASRC = 12'b0000_0000_1000;
    localparam logic [11:0] BR   = 12'b0000_0000_0100;
    localparam logic [11:0] RW   = 12'b0000_0000_0010;
    localparam logic [11:0] ILL  = 12'b0000_0000_0001;

    typedef struct {
        logic        rst;
        logic        fa;
        logic        ma;
        logic        bt;
        logic [6:0]  op;
        logic [11:0] ctl;
        logic [3:0]  aopt;
        logic [1:0]  al;
        logic [31:0] ir;
    } cyc_t;

    cyc_t        trace[$];
    cyc_t        cur;
    bit          check_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] mdl_instret = 32'd0;
    logic [6:0]  mdl_prev = 7'd0;
    logic [31:0] nxt_instret;
    logic [6:0]  nxt_prev;

    function automatic logic [3:0] key_of(input logic [6:0] o);
        return {o[6:4], o[2]};
    endfunction

    function automatic cyc_t mk(input logic [6:0] op, input logic [3:0] aopt,
                                input logic [31:0] cnt);
        cyc_t c;
        c.rst  = 1'b0;
        c.fa   = 1'($urandom);
        c.ma   = 1'($urandom);
        c.bt   = 1'($urandom);
        c.op   = op;
        c.ctl  = 12'd0;
        c.aopt = aopt;
        c.al   = 2'b10;
        c.ir   = cnt;
        return c;
    endfunction

    function automatic cyc_t rst_cyc(input logic fa);
        cyc_t c;
        c.rst  = 1'b1;
        c.fa   = fa;
        c.ma   = 1'($urandom);
        c.bt   = 1'($urandom);
        c.op   = 7'($urandom);
        c.ctl  = 12'd0;
        c.aopt = 4'd0;
        c.al   = 2'b00;
        c.ir   = 32'd0;
        return c;
    endfunction

    // Expected cycle-by-cycle trace for one instruction with the given ack delays.
    task automatic build(input logic [6:0] op, input int fd, input int md, input logic bt);
        cyc_t        c;
        string       cls;
        logic [3:0]  k = key_of(op);
        logic [3:0]  pk = key_of(mdl_prev);
        logic [31:0] cnt = mdl_instret;
        case (k)
            4'b0000: cls = "LOAD";
            4'b0010: cls = "ITYPE";
            4'b0011: cls = "AUIPC";
            4'b0100: cls = "STORE";
            4'b0110: cls = "RTYPE";
            4'b0111: cls = "LUI";
            4'b1100: cls = "BRANCH";
            default: cls = "ILLEGAL";
        endcase
        trace.delete();
        for (int i = 0; i <= fd; i++) begin
            c = mk(7'($urandom), pk, cnt);
            c.fa  = (i == fd);
            c.ctl = FREQ | ((i == fd) ? IRW : 12'd0);
            trace.push_back(c);
        end
        c = mk(op, pk, cnt);
        nxt_prev = op;
        if (cls == "ILLEGAL") begin
            c.ctl = PCW | ILL;
            trace.push_back(c);
            nxt_instret = cnt;
            return;
        end
        trace.push_back(c);
        c = mk(op, k, cnt);
        case (cls)
            "LOAD", "STORE", "ITYPE": c.ctl = ASRC;
            "AUIPC": begin c.ctl = ASRC; c.al = 2'b00; end
            "LUI":   begin c.ctl = ASRC; c.al = 2'b01; end
            "BRANCH": begin c.bt = bt; c.ctl = BR | PCW | (bt ? PCS : 12'd0); end
            default: c.ctl = 12'd0;
        endcase
        trace.push_back(c);
        if (cls == "BRANCH") begin
            nxt_instret = cnt + 32'd1;
            return;
        end
        if (cls == "LOAD" || cls == "STORE") begin
            for (int i = 0; i <= md; i++) begin
                c = mk(op, k, cnt);
                c.ma  = (i == md);
                c.ctl = MREQ | ((cls == "LOAD") ? MRD : MWR);
                if (cls == "STORE" && i == md) c.ctl = c.ctl | PCW;
                trace.push_back(c);
            end
            if (cls == "STORE") begin
                nxt_instret = cnt + 32'd1;
                return;
            end
        end
        c = mk(op, k, cnt);
        c.ctl = RW | PCW | ((cls == "LOAD") ? M2R : 12'd0);
        trace.push_back(c);
        nxt_instret = cnt + 32'd1;
    endtask

    task automatic drive(input cyc_t c);
        @(posedge clk);
        #1;
        reset        = c.rst;
        fetch_ack    = c.fa;
        mem_ack      = c.ma;
        branch_taken = c.bt;
        opcode       = c.op;
        cur          = c;
        check_en     = 1'b1;
    endtask

    // Plays the built trace; abort_at >= 0 cuts it short with nrst reset cycles.
    task automatic play(input int abort_at, input int nrst);
        int n = trace.size();
        if (abort_at >= 0 && abort_at < n) n = abort_at;
        for (int i = 0; i < n; i++) drive(trace[i]);
        if (n < trace.size()) begin
            for (int i = 0; i < nrst; i++) drive(rst_cyc(1'($urandom)));
            mdl_instret = 32'd0;
            mdl_prev    = 7'd0;
        end else begin
            mdl_instret = nxt_instret;
            mdl_prev    = nxt_prev;
        end
    endtask

    task automatic check_lit(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            n_checks++;
            if ({fetch_req, ir_write, pc_write, pc_source, mem_req, memory_read, memory_write,
                 memory_to_register, alu_source, branch, register_write, illegal_instr}
                !== cur.ctl) begin
                n_fail++;
                $display("FAIL ctl @%0t: got %b expected %b", $time,
                         {fetch_req, ir_write, pc_write, pc_source, mem_req, memory_read,
                          memory_write, memory_to_register, alu_source, branch,
                          register_write, illegal_instr}, cur.ctl);
            end
            n_checks++;
            if (alu_option !== cur.aopt || AuipcLui !== cur.al) begin
                n_fail++;
                $display("FAIL alu_sel @%0t: got opt=%b al=%b expected opt=%b al=%b", $time,
                         alu_option, AuipcLui, cur.aopt, cur.al);
            end
            n_checks++;
            if (instret !== cur.ir) begin
                n_fail++;
                $display("FAIL instret @%0t: got %0d expected %0d", $time, instret, cur.ir);
            end
        end
    end

    localparam logic [6:0] OPS [7] = '{7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011,
                                        7'b0110011, 7'b0110111, 7'b1100011};

    initial begin
        logic [6:0] op;
        int         ab;
        for (int i = 0; i < 3; i++) drive(rst_cyc(1'b1));

        build(7'b0110011, 0, 0, 1'b0);
        check_lit("rtype_len", trace.size(), 4);
        play(-1, 0);
        check_lit("rtype_instret", int'(mdl_instret), 1);
        build(7'b0000011, 0, 3, 1'b0);
        check_lit("load_len", trace.size(), 8);
        play(-1, 0);
        build(7'b1100011, 0, 0, 1'b1);
        check_lit("branch_len", trace.size(), 3);
        play(-1, 0);
        build(7'b1100011, 0, 0, 1'b0);
        play(-1, 0);
        build(7'b0110111, 0, 0, 1'b0);
        check_lit("lui_len", trace.size(), 4);
        play(-1, 0);
        build(7'b0010111, 0, 0, 1'b0);
        play(-1, 0);
        build(7'b1101111, 0, 0, 1'b0);
        check_lit("illegal_len", trace.size(), 2);
        play(-1, 0);
        check_lit("instret_after_illegal", int'(mdl_instret), 6);
        // Store aborted by reset in the middle of its memory stall.
        build(7'b0100011, 0, 2, 1'b0);
        play(4, 2);
        check_lit("instret_after_abort", int'(mdl_instret), 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(7) == 0) op = 7'($urandom);
            else op = OPS[$urandom_range(6)];
            build(op, $urandom_range(3), $urandom_range(3), 1'($urandom));
            ab = ($urandom_range(19) == 0) ? $urandom_range(trace.size() - 1) : -1;
            play(ab, $urandom_range(1, 2));
        end

        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
